// File: rtl/pix_pair_packer.sv
// Packs filtered ADC sample pairs into tagged 32-bit words and buffers them in a
// small FIFO for the frame-buffer write path; tracks frame geometry and drop stats.
module pix_pair_packer #(
    parameter int ADC_WIDHT       = 14,
    parameter int PAIRS_PER_LINE  = 192,
    parameter int LINES_PER_FRAME = 288,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic                 FRAME_START,
    input  logic                 IN_VALID,
    input  logic [ADC_WIDHT-1:0] IN_ADC1,
    input  logic [ADC_WIDHT-1:0] IN_ADC2,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_SOF,
    output logic                 OUT_EOL,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [15:0]          OVERFLOW_CNT,
    output logic [7:0]           GEOM_ERR_CNT,
    output logic                 BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PAIRS_PER_LINE);
    localparam int RW = $clog2(LINES_PER_FRAME);

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } word_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_RUN} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    word_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          pop, full, restart, push_req, do_push, drop, last_col, last_pair;
    logic [CW-1:0] tag_col;
    logic [RW-1:0] tag_row;
    word_t         new_word;

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = mem[rd_ptr].data;
    assign OUT_SOF   = mem[rd_ptr].sof;
    assign OUT_EOL   = mem[rd_ptr].eol;
    assign BUSY      = (state == S_RUN);

    // An early FRAME_START retags a coincident pair as position (0,0).
    assign restart   = ENABLE && (state == S_RUN) && FRAME_START;
    assign push_req  = ENABLE && (state == S_RUN) && IN_VALID;
    assign tag_col   = restart ? '0 : col;
    assign tag_row   = restart ? '0 : row;
    assign last_col  = (tag_col == CW'(PAIRS_PER_LINE - 1));
    assign last_pair = last_col && (tag_row == RW'(LINES_PER_FRAME - 1));

    assign pop     = OUT_VALID && OUT_READY;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_push = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    assign new_word.sof  = (tag_col == '0) && (tag_row == '0);
    assign new_word.eol  = last_col;
    assign new_word.data = {16'(IN_ADC2), 16'(IN_ADC1)};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            col          <= '0;
            row          <= '0;
            GEOM_ERR_CNT <= '0;
        end else if (!ENABLE) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_WAIT_SOF;
                S_WAIT_SOF: begin
                    if (FRAME_START) begin
                        state <= S_RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                S_RUN: begin
                    if (FRAME_START) begin
                        if (GEOM_ERR_CNT != '1) GEOM_ERR_CNT <= GEOM_ERR_CNT + 8'd1;
                        col <= '0;
                        row <= '0;
                    end
                    // Geometry advances even when the pair is dropped.
                    if (IN_VALID) begin
                        if (last_pair) begin
                            state <= S_WAIT_SOF;
                            col   <= '0;
                            row   <= '0;
                        end else if (last_col) begin
                            col <= '0;
                            row <= tag_row + RW'(1);
                        end else begin
                            col <= tag_col + CW'(1);
                            row <= tag_row;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            OVERFLOW_CNT <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= new_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
            if (drop && OVERFLOW_CNT != '1) OVERFLOW_CNT <= OVERFLOW_CNT + 16'd1;
        end
    end
endmodule
